div_unit: RTL and testbench

//  Iterative multi-cycle integer divider for the pipeline CPU's multiply/divide unit.

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring shift-subtract divider, one quotient bit per clock.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   start  pulse that latches A/B and begins a division; ignored while Busy
//   A, B   dividend and divisor, sampled only on the accepting start edge
//   Busy   high while a division is in flight (WIDTH+2 cycles)
//   HI     remainder of the last completed division
//   LO     quotient of the last completed division
module div_unit #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, bmag_q, bmag_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             sign_a, sign_b;
    logic [WIDTH+1:0] part;

    assign sign_a = SIGNED && a_q[WIDTH-1];
    assign sign_b = SIGNED && b_q[WIDTH-1];
    // Remainder shifted left with the next dividend bit; one spare top bit so the compare never loses a carry.
    assign part   = {rem_q, quo_q[WIDTH-1]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        bmag_d    = bmag_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_quo_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                quo_d     = sign_a ? -a_q : a_q;
                bmag_d    = sign_b ? -b_q : b_q;
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = ITER;
            end
            ITER: begin
                rem_d   = (part >= {2'b00, bmag_q}) ? (WIDTH+1)'(part - {2'b00, bmag_q}) : (WIDTH+1)'(part);
                quo_d   = {quo_q[WIDTH-2:0], part >= {2'b00, bmag_q}};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : ITER;
            end
            FIX: begin
                // Divide by zero reports all-ones quotient and the dividend as remainder, regardless of sign mode.
                lo_d    = (b_q == '0) ? '1 : (neg_quo_q ? -quo_q : quo_q);
                hi_d    = (b_q == '0) ? a_q : (neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            bmag_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            bmag_q    <= bmag_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for signed and unsigned div_unit instances.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy_s, busy_u;
    logic [W-1:0] hi_s, lo_s, hi_u, lo_u;
    logic [2*W-1:0] q_s[$], q_u[$];
    logic [2*W-1:0] last_s = '0, last_u = '0;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
        .Busy(busy_s), .HI(hi_s), .LO(lo_s)
    );
    div_unit #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
        .Busy(busy_u), .HI(hi_u), .LO(lo_u)
    );

    function automatic logic [2*W-1:0] model(logic [W-1:0] x, logic [W-1:0] y, bit sgn);
        logic [W-1:0] min_v;
        min_v = {1'b1, {(W-1){1'b0}}};
        if (y == '0) return {x, {W{1'b1}}};
        if (sgn) begin
            if (x == min_v && y == '1) return {{W{1'b0}}, min_v};
            return {W'($signed(x) % $signed(y)), W'($signed(x) / $signed(y))};
        end
        return {x % y, x / y};
    endfunction

    task automatic check(string tag, logic [2*W-1:0] obs, logic [2*W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(logic [W-1:0] x, logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        q_s.push_back(model(x, y, 1'b1));
        q_u.push_back(model(x, y, 1'b0));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(logic [W-1:0] x, logic [W-1:0] y, bit ign, string tag);
        int cyc;
        logic [2*W-1:0] e;
        pulse(x, y);
        cyc = 0;
        while (busy_s && cyc < 100) begin
            cyc++;
            if (cyc == 17) begin
                check({tag, " hold_s"}, {hi_s, lo_s}, last_s);
                check({tag, " hold_u"}, {hi_u, lo_u}, last_u);
            end
            start = ign && cyc == 5;
            if (start) begin
                a = 9;
                b = 3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(cyc), 64'(W + 2));
        check({tag, " busy_u"}, 64'(busy_u), 64'(0));
        e = (q_s.size() != 0) ? q_s.pop_front() : 'x;
        check({tag, " hilo_s"}, {hi_s, lo_s}, e);
        last_s = e;
        e = (q_u.size() != 0) ? q_u.pop_front() : 'x;
        check({tag, " hilo_u"}, {hi_u, lo_u}, e);
        last_u = e;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_s", {31'b0, busy_s, hi_s, lo_s}, '0);
        check("reset_u", {31'b0, busy_u, hi_u, lo_u}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_s", {31'b0, busy_s, hi_s, lo_s}, '0);
        run(32'd21, 32'd5, 1'b0, "21/5");
        run(32'hFFFF_FFEB, 32'd5, 1'b0, "-21/5");
        run(32'd7, 32'd0, 1'b0, "7/0");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "min/-1");
        run(32'd100, 32'd7, 1'b1, "100/7+ignored");
        check("queue_empty", 64'(q_s.size() + q_u.size()), 64'(0));
        pulse(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_s", {31'b0, busy_s, hi_s, lo_s}, '0);
        check("abort_u", {31'b0, busy_u, hi_u, lo_u}, '0);
        q_s.delete();
        q_u.delete();
        last_s = '0;
        last_u = '0;
        @(negedge clk);
        reset = 1'b0;
        run(32'd9, 32'd3, 1'b0, "9/3");
        run(32'hFFFF_FFFF, 32'd1, 1'b0, "max/1");
        run(32'd0, 32'hFFFF_FFF9, 1'b0, "0/-7");
        run(32'd5, 32'd9, 1'b0, "5/9");
        for (int i = 0; i < 4; i++)
            run($urandom, (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom, 1'b0, "random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
